victim_way_sel: RTL and testbench
=================================

// Module: victim_way_sel
// PURPOSE
//  Replacement-way selector, directly downstream of the fixed-priority invalid-way arbiter.
//  - Holds per-set tree pseudo-LRU (PLRU) state.
//  - On a miss lookup, picks one victim way:
//    - the arbiter's invalid-way grant when it is valid;
//    - otherwise the PLRU victim.
//  - Hits and fills update the PLRU state.
//  - Feeds victim_way to the refill/writeback controller.
// PARAMETERS
//  WAY_NUM   4   ways per set; power of 2, >=2
//  SET_NUM   64  sets; power of 2
//  IDX_W     $clog2(SET_NUM)  set index width (derived, not overridden)
// PORTS
//  clk             in   1         single clock, rising edge
//  rst             in   1         synchronous, active-high reset
//  lookup_valid    in   1         miss lookup request this cycle
//  lookup_index    in   IDX_W     set index of lookup
//  inv_grant       in   WAY_NUM   one-hot invalid way from arbiter (same cycle as lookup)
//  inv_grant_valid in   1         at least one invalid way exists
//  access_valid    in   1         hit or fill touched a way; update PLRU
//  access_index    in   IDX_W     set index of access
//  access_way      in   WAY_NUM   one-hot way accessed
//  victim_valid    out  1         victim result valid (1-cycle pulse)
//  victim_way      out  WAY_NUM   one-hot victim way
//  victim_is_inv   out  1         1: victim came from inv_grant; 0: from PLRU
// BEHAVIOUR
//  - PLRU state: SET_NUM entries x (WAY_NUM-1) bits, heap-indexed nodes 1..WAY_NUM-1.
//    - Node n has children 2n and 2n+1; leaves map to ways 0..WAY_NUM-1, left to right.
//    - Node bit 0: victim lies in the left subtree. Node bit 1: victim lies in the right subtree.
//  - Update on access_valid to way w at access_index:
//    - every node on w's path is set to point away from w;
//    - off-path nodes are unchanged;
//    - the write takes effect at the next clock edge.
//  - Lookup latency is exactly 1 cycle.
//    - A lookup_valid sampled at edge E gives victim_valid=1 for the cycle after E.
//    - Outputs are registered.
//    - A lookup every cycle is allowed, one result per cycle.
//    - There is no backpressure and no stall.
//  - Selection:
//    - if inv_grant_valid: victim_way = inv_grant, victim_is_inv = 1;
//    - else: victim_way = PLRU decode of lookup_index's state, victim_is_inv = 0.
//  - Bypass: if access_valid && access_index == lookup_index in the same cycle, the PLRU
//    decode uses the post-update state.
//  - When victim_valid=0: victim_way = 0 and victim_is_inv = 0 (outputs are zeroed, not held).
//  - access_way = 0 -> no update.
//  - access_way not one-hot -> no update, and a simulation assertion fires.
//  - inv_grant must be one-hot whenever inv_grant_valid=1 (assertion). Otherwise it is ignored.
//  - Reset, whenever rst=1 at an edge:
//    - all PLRU bits clear to 0, so every set's victim is way 0;
//    - victim_valid=0, victim_way=0, victim_is_inv=0;
//    - a lookup or access present in a reset cycle is dropped.
//    - Reset mid-stream: the cycle after the reset edge shows no result.
//  - The module does not track its own fills. The controller must send access_valid for the
//    filled way; until then PLRU is unchanged.
// STRUCTURE
//  - Shared package cache_pkg:
//    - WAY_NUM, SET_NUM, IDX_W;
//    - typedef logic [WAY_NUM-1:0] way_oh_t;
//    - typedef logic [WAY_NUM-1:1] plru_t.
//  - Sub-module plru_tree_dec, combinational, parameterised by WAY_NUM:
//    - inputs: plru_t state, way_oh_t acc_way, acc_en;
//    - outputs: plru_t next_state, way_oh_t victim.
//    - Instanced twice: one for the access update, one for the lookup decode on bypassed state.
//  - Top: state array (flops; reset-cleared), bypass compare, output registers.
// TESTING  (WAY_NUM=4, SET_NUM=4)
//  - Reset, then lookup idx0 with inv_grant_valid=0
//    -> next cycle victim_valid=1, victim_way=4'b0001, victim_is_inv=0.
//  - Access idx0 way0; next cycle lookup idx0 -> victim 4'b0100.
//    Then access way2; lookup -> victim 4'b0010.
//  - Lookup idx1 with inv_grant=4'b1000, inv_grant_valid=1
//    -> victim 4'b1000, victim_is_inv=1, PLRU idx1 unchanged.
//  - Same cycle: access idx2 way0 + lookup idx2 -> victim 4'b0100 (bypass).
//    Same with access idx3 -> victim 4'b0001.
//  - Back-to-back lookups idx0..3 on 4 cycles -> 4 consecutive victim_valid pulses, in order.
//  - Access sets 0..3 to non-zero states, assert rst 1 cycle with lookup_valid=1
//    -> no victim_valid next cycle; subsequent lookups all return 4'b0001.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache-side definitions for the replacement path.
//   WAY_NUM / SET_NUM / IDX_W : default cache geometry
//   way_oh_t                  : one-hot way vector
//   plru_t                    : heap-indexed tree-PLRU node bits (nodes 1..WAY_NUM-1)
//   multi_hot                 : true when a vector has two or more bits set
package cache_pkg;

  localparam int WAY_NUM = 4;
  localparam int SET_NUM = 64;
  localparam int IDX_W   = $clog2(SET_NUM);

  typedef logic [WAY_NUM-1:0] way_oh_t;
  typedef logic [WAY_NUM-1:1] plru_t;

  // Zero and one-hot are both legal "not multi-hot" values.
  function automatic logic multi_hot(input logic [63:0] vec);
    return (vec & (vec - 64'd1)) != 64'd0;
  endfunction

endpackage

// File: rtl/plru_tree_dec.sv
// Combinational tree-PLRU helper.
//   state      : current node bits of one set (node n children are 2n and 2n+1)
//   acc_way    : one-hot way being touched
//   acc_en     : apply the touch; ignored unless acc_way is exactly one-hot
//   next_state : state with every node on acc_way's path pointing away from it
//   victim     : one-hot victim decoded from next_state (0 = go left, 1 = go right)
module plru_tree_dec
  import cache_pkg::*;
#(
  parameter int WAY_NUM = cache_pkg::WAY_NUM
) (
  input  logic [WAY_NUM-1:1] state,
  input  logic [WAY_NUM-1:0] acc_way,
  input  logic               acc_en,
  output logic [WAY_NUM-1:1] next_state,
  output logic [WAY_NUM-1:0] victim
);

  localparam int LVL = $clog2(WAY_NUM);

  always_comb begin
    int   leaf;
    int   node;
    logic touch;

    next_state = state;
    victim     = '0;
    leaf       = 0;
    node       = 1;
    touch      = acc_en && (acc_way != '0) &&
                 ((acc_way & (acc_way - 1'b1)) == '0);

    // Heap number of the accessed leaf: ways sit at WAY_NUM..2*WAY_NUM-1.
    for (int w = 0; w < WAY_NUM; w++) begin
      if (acc_way[w]) leaf = w + WAY_NUM;
    end

    // Ancestor at depth l is leaf >> (LVL-l); the next bit down says which
    // child the access went to, so the node is set to the opposite side.
    if (touch) begin
      for (int l = 0; l < LVL; l++) begin
        for (int n = 1; n < WAY_NUM; n++) begin
          if (n == (leaf >> (LVL - l)))
            next_state[n] = (((leaf >> (LVL - 1 - l)) & 1) == 0);
        end
      end
    end

    // Walk from the root following the node bits.
    for (int l = 0; l < LVL; l++) begin
      logic dir;
      dir = 1'b0;
      for (int n = 1; n < WAY_NUM; n++) begin
        if (n == node) dir = next_state[n];
      end
      node = 2 * node + (dir ? 1 : 0);
    end

    for (int w = 0; w < WAY_NUM; w++) begin
      victim[w] = (node == w + WAY_NUM);
    end
  end

endmodule

// File: rtl/victim_way_sel.sv
// Replacement-way selector with per-set tree-PLRU state.
//   clk, rst          : clock, synchronous active-high reset
//   lookup_valid/index: miss lookup; result one cycle later
//   inv_grant(_valid) : one-hot invalid way from the arbiter, preferred victim
//   access_valid/index/way : hit or fill touching a way, updates PLRU
//   victim_valid      : one-cycle result pulse
//   victim_way        : one-hot victim (zero when no result)
//   victim_is_inv     : victim taken from inv_grant rather than PLRU
module victim_way_sel
  import cache_pkg::*;
#(
  parameter int  WAY_NUM = cache_pkg::WAY_NUM,
  parameter int  SET_NUM = cache_pkg::SET_NUM,
  localparam int IDX_W   = $clog2(SET_NUM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lookup_valid,
  input  logic [IDX_W-1:0]   lookup_index,
  input  logic [WAY_NUM-1:0] inv_grant,
  input  logic               inv_grant_valid,
  input  logic               access_valid,
  input  logic [IDX_W-1:0]   access_index,
  input  logic [WAY_NUM-1:0] access_way,
  output logic               victim_valid,
  output logic [WAY_NUM-1:0] victim_way,
  output logic               victim_is_inv
);

  logic [WAY_NUM-1:1] plru_q [SET_NUM];

  logic [WAY_NUM-1:1] upd_next;
  logic [WAY_NUM-1:0] upd_victim_unused;
  logic [WAY_NUM-1:1] lkp_next_unused;
  logic [WAY_NUM-1:0] lkp_victim;
  logic               bypass;

  // Same-cycle access to the looked-up set is folded in before decoding.
  assign bypass = access_valid && (access_index == lookup_index);

  plru_tree_dec #(.WAY_NUM(WAY_NUM)) u_upd (
    .state      (plru_q[access_index]),
    .acc_way    (access_way),
    .acc_en     (access_valid),
    .next_state (upd_next),
    .victim     (upd_victim_unused)
  );

  plru_tree_dec #(.WAY_NUM(WAY_NUM)) u_lkp (
    .state      (plru_q[lookup_index]),
    .acc_way    (access_way),
    .acc_en     (bypass),
    .next_state (lkp_next_unused),
    .victim     (lkp_victim)
  );

  // Stage boundary: state write-back and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SET_NUM; s++) plru_q[s] <= '0;
      victim_valid  <= 1'b0;
      victim_way    <= '0;
      victim_is_inv <= 1'b0;
    end else begin
      if (access_valid) plru_q[access_index] <= upd_next;
      victim_valid  <= lookup_valid;
      victim_is_inv <= lookup_valid && inv_grant_valid;
      if (!lookup_valid)       victim_way <= '0;
      else if (inv_grant_valid) victim_way <= inv_grant;
      else                      victim_way <= lkp_victim;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(access_valid && multi_hot(64'(access_way))))
        else $error("access_way not one-hot: %b", access_way);
      assert (!(lookup_valid && inv_grant_valid &&
                ((inv_grant == '0) || multi_hot(64'(inv_grant)))))
        else $error("inv_grant not one-hot: %b", inv_grant);
    end
  end

endmodule

// File: tb/tb_victim_way_sel.sv
module tb_victim_way_sel;

  localparam int WN = 4;
  localparam int SN = 4;
  localparam int IW = 2;
  localparam int LV = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          lookup_valid;
  logic [IW-1:0] lookup_index;
  logic [WN-1:0] inv_grant;
  logic          inv_grant_valid;
  logic          access_valid;
  logic [IW-1:0] access_index;
  logic [WN-1:0] access_way;
  logic          victim_valid;
  logic [WN-1:0] victim_way;
  logic          victim_is_inv;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: tree[set][node] holds the node bit, node 1 is the root.
  int tree [SN][WN];

  always #5 clk = ~clk;

  victim_way_sel #(.WAY_NUM(WN), .SET_NUM(SN)) dut (
    .clk             (clk),
    .rst             (rst),
    .lookup_valid    (lookup_valid),
    .lookup_index    (lookup_index),
    .inv_grant       (inv_grant),
    .inv_grant_valid (inv_grant_valid),
    .access_valid    (access_valid),
    .access_index    (access_index),
    .access_way      (access_way),
    .victim_valid    (victim_valid),
    .victim_way      (victim_way),
    .victim_is_inv   (victim_is_inv)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int oh2idx(input logic [WN-1:0] v);
    int r = 0;
    for (int i = 0; i < WN; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Walk root-to-leaf along the way number's bits, msb first; each node
  // is made to point to the side not taken.
  task automatic model_touch(input int s, input int w);
    int n = 1;
    for (int l = 0; l < LV; l++) begin
      int dir = (w >> (LV - 1 - l)) & 1;
      tree[s][n] = (dir == 0) ? 1 : 0;
      n = 2 * n + dir;
    end
  endtask

  function automatic int model_victim(input int s);
    int n = 1;
    for (int l = 0; l < LV; l++) n = 2 * n + tree[s][n];
    return n - WN;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < SN; s++)
      for (int n = 0; n < WN; n++) tree[s][n] = 0;
  endtask

  task automatic do_cycle(input bit r, input bit lv, input int li,
                          input logic [WN-1:0] ig, input bit igv,
                          input bit av, input int ai, input logic [WN-1:0] aw);
    bit            ev;
    bit            ei;
    logic [WN-1:0] ew;
    rst             = r;
    lookup_valid    = lv;
    lookup_index    = IW'(li);
    inv_grant       = ig;
    inv_grant_valid = igv;
    access_valid    = av;
    access_index    = IW'(ai);
    access_way      = aw;
    if (r) begin
      model_clear();
      ev = 0; ei = 0; ew = '0;
    end else begin
      // Access first so a same-set lookup sees the updated tree.
      if (av && aw != '0) model_touch(ai, oh2idx(aw));
      ev = lv;
      ei = lv && igv;
      if (!lv)      ew = '0;
      else if (igv) ew = ig;
      else          ew = WN'(1) << model_victim(li);
    end
    @(posedge clk);
    #1;
    chk("victim_valid", 32'(victim_valid), 32'(ev));
    chk("victim_way", 32'(victim_way), 32'(ew));
    chk("victim_is_inv", 32'(victim_is_inv), 32'(ei));
  endtask

  initial begin
    model_clear();
    do_cycle(1, 0, 0, '0, 0, 0, 0, '0);
    do_cycle(1, 1, 0, '0, 0, 1, 0, 4'b0001);
    chk("reset_valid", 32'(victim_valid), 32'd0);

    do_cycle(0, 1, 0, '0, 0, 0, 0, '0);
    chk("first_lookup", 32'(victim_way), 32'h1);
    do_cycle(0, 0, 0, '0, 0, 1, 0, 4'b0001);
    chk("idle_zero", 32'(victim_way), 32'h0);
    do_cycle(0, 1, 0, '0, 0, 0, 0, '0);
    chk("after_way0", 32'(victim_way), 32'h4);
    do_cycle(0, 0, 0, '0, 0, 1, 0, 4'b0100);
    do_cycle(0, 1, 0, '0, 0, 0, 0, '0);
    chk("after_way2", 32'(victim_way), 32'h2);

    do_cycle(0, 1, 1, 4'b1000, 1, 0, 0, '0);
    chk("inv_way", 32'(victim_way), 32'h8);
    chk("inv_flag", 32'(victim_is_inv), 32'h1);
    do_cycle(0, 1, 1, '0, 0, 0, 0, '0);
    chk("inv_no_update", 32'(victim_way), 32'h1);

    do_cycle(0, 1, 2, '0, 0, 1, 2, 4'b0001);
    chk("bypass_hit", 32'(victim_way), 32'h4);
    do_cycle(0, 1, 3, '0, 0, 1, 2, 4'b0001);
    chk("bypass_other_set", 32'(victim_way), 32'h1);

    for (int s = 0; s < SN; s++) do_cycle(0, 1, s, '0, 0, 0, 0, '0);

    for (int s = 0; s < SN; s++) do_cycle(0, 0, 0, '0, 0, 1, s, 4'b0010);
    do_cycle(1, 1, 1, '0, 0, 1, 1, 4'b0001);
    chk("mid_reset_drop", 32'(victim_valid), 32'd0);
    for (int s = 0; s < SN; s++) begin
      do_cycle(0, 1, s, '0, 0, 0, 0, '0);
      chk("post_reset_way", 32'(victim_way), 32'h1);
    end

    for (int i = 0; i < 1500; i++) begin
      bit            r   = ($urandom_range(0, 99) == 0);
      bit            lv  = ($urandom_range(0, 3) != 0);
      bit            igv = ($urandom_range(0, 2) == 0);
      bit            av  = ($urandom_range(0, 1) == 1);
      logic [WN-1:0] ig;
      logic [WN-1:0] aw;
      ig = igv ? (WN'(1) << $urandom_range(0, WN - 1)) : WN'($urandom);
      aw = ($urandom_range(0, 7) == 0) ? '0 : (WN'(1) << $urandom_range(0, WN - 1));
      do_cycle(r, lv, $urandom_range(0, SN - 1), ig, igv, av,
               $urandom_range(0, SN - 1), aw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
